// File: rtl/mdio_phy_resp.sv
// mdio_phy_resp: Clause-22 MDIO responder with a small PHY register file.
// MDC/MDIO are oversampled in the clk domain; all logic runs on clk.
//
// state | meaning
// IDLE  | counting preamble ones
// ST    | second start bit
// OP    | opcode bits
// PHYAD | PHY address bits
// REGAD | register address bits
// TA    | turnaround
// RDATA | driving read data
// WDATA | shifting in write data

module mdio_phy_resp #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2,
  parameter logic [15:0] RST_CYC  = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  input  logic [1:0]  speed_in,
  output logic [15:0] bmcr_o,
  output logic        soft_rst_o
);

  typedef enum logic [2:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA
  } state_t;

  state_t      state, state_nxt;
  logic        mdc_s1, mdc_s2, mdc_d, mdio_s1, mdio_s2;
  logic        rise, fall, bit_in;
  logic [4:0]  bit_cnt, regad, addr_now;
  logic [5:0]  pre_cnt;
  logic [15:0] shreg, rd_sh, rd_mux, rst_cnt;
  logic        is_rd, wr_pend, link_latched, regad_done;

  assign rise       = mdc_s2 & ~mdc_d;
  assign fall       = ~mdc_s2 & mdc_d;
  assign bit_in     = mdio_s2;
  assign addr_now   = {shreg[3:0], bit_in};
  assign regad_done = (state == REGAD) && rise && (bit_cnt == 5'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_d   <= 1'b0;
      mdio_s1 <= 1'b0;
      mdio_s2 <= 1'b0;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_d   <= mdc_s2;
      mdio_s1 <= mdio_i;
      mdio_s2 <= mdio_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rise) begin
      case (state)
        IDLE:  if (!bit_in && pre_cnt == 6'd32) state_nxt = ST;
        ST:    state_nxt = bit_in ? OP : IDLE;
        OP:    if (bit_cnt == 5'd1)
                 state_nxt = (shreg[0] != bit_in) ? PHYAD : IDLE;
        PHYAD: if (bit_cnt == 5'd4)
                 state_nxt = (addr_now == PHY_ADDR) ? REGAD : IDLE;
        REGAD: if (bit_cnt == 5'd4) state_nxt = TA;
        TA:    if (bit_cnt == 5'd1) state_nxt = is_rd ? RDATA : WDATA;
        WDATA: if (bit_cnt == 5'd15) state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end else if (fall && state == RDATA && bit_cnt == 5'd16) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (addr_now)
      5'h00: rd_mux = bmcr_o;
      5'h01: rd_mux = 16'h7909 | {10'b0, link_up, 2'b00, link_latched, 2'b00};
      5'h02: rd_mux = PHY_ID1;
      5'h03: rd_mux = PHY_ID2;
      5'h1A: rd_mux = {10'b0, speed_in, 1'b0, link_up, 2'b00};
      default: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      pre_cnt <= '0;
      is_rd   <= 1'b0;
      regad   <= '0;
      rd_sh   <= '0;
      mdio_oe <= 1'b0;
      mdio_o  <= 1'b1;
      wr_pend <= 1'b0;
    end else begin
      if (rise) shreg <= {shreg[14:0], bit_in};

      if (state_nxt != state) bit_cnt <= '0;
      else if (rise)          bit_cnt <= bit_cnt + 5'd1;

      // Any frame activity (including leaving IDLE) restarts the preamble count.
      if (state != IDLE || state_nxt != IDLE) pre_cnt <= '0;
      else if (rise) begin
        if (!bit_in)                pre_cnt <= '0;
        else if (pre_cnt != 6'd32)  pre_cnt <= pre_cnt + 6'd1;
      end

      if (state == OP && rise && bit_cnt == 5'd1)
        is_rd <= (shreg[0] && !bit_in);

      if (regad_done) begin
        regad <= addr_now;
        rd_sh <= rd_mux;
      end

      if (state == TA && is_rd && fall && bit_cnt == 5'd1) begin
        mdio_oe <= 1'b1;
        mdio_o  <= 1'b0;
      end else if (state == RDATA && fall) begin
        if (bit_cnt == 5'd16) begin
          mdio_oe <= 1'b0;
          mdio_o  <= 1'b1;
        end else begin
          mdio_o <= rd_sh[15];
          rd_sh  <= {rd_sh[14:0], 1'b0};
        end
      end

      wr_pend <= (state == WDATA) && rise && (bit_cnt == 5'd15);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_latched <= 1'b0;
      bmcr_o       <= 16'h1140;
      soft_rst_o   <= 1'b0;
      rst_cnt      <= '0;
    end else begin
      soft_rst_o <= 1'b0;

      // Latched-low link: the read above already captured the old value.
      if (!link_up)
        link_latched <= 1'b0;
      else if (regad_done && is_rd && addr_now == 5'h01)
        link_latched <= 1'b1;

      if (wr_pend && regad == 5'h00 && !bmcr_o[15]) begin
        if (shreg[15]) begin
          bmcr_o     <= 16'h9140;
          soft_rst_o <= 1'b1;
          rst_cnt    <= RST_CYC;
        end else begin
          bmcr_o <= {1'b0, shreg[14:0]};
        end
      end else if (bmcr_o[15]) begin
        if (rst_cnt <= 16'd1) begin
          bmcr_o[15] <= 1'b0;
          rst_cnt    <= '0;
        end else begin
          rst_cnt <= rst_cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_resp.sv
// Testbench for mdio_phy_resp: a station model drives Clause-22 frames, a
// scoreboard queue holds expected read responses, and a monitor checks them.

module tb_mdio_phy_resp;

  localparam int RSTC = 2000;

  typedef struct packed {
    logic        abort_exp;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdc = 1'b0;
  logic        link_up = 1'b0;
  logic [1:0]  speed_in = 2'b00;
  logic        st_oe = 1'b0;
  logic        st_drv = 1'b1;
  logic        mdio_line;
  logic        mdio_o, mdio_oe, soft_rst_o;
  logic [15:0] bmcr_o;

  int total = 0;
  int bad = 0;
  int oe_cnt = 0, sr_cnt = 0, hi_cnt = 0;
  exp_t exp_q[$];

  logic [15:0] m_bmcr = 16'h1140;
  logic        m_latched = 1'b0;

  assign mdio_line = mdio_oe ? mdio_o : (st_oe ? st_drv : 1'b1);

  mdio_phy_resp #(.RST_CYC(16'(RSTC))) dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_line),
    .mdio_o(mdio_o), .mdio_oe(mdio_oe), .link_up(link_up),
    .speed_in(speed_in), .bmcr_o(bmcr_o), .soft_rst_o(soft_rst_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mdio_oe)    oe_cnt <= oe_cnt + 1;
    if (soft_rst_o) sr_cnt <= sr_cnt + 1;
    if (bmcr_o[15]) hi_cnt <= hi_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [4:0] a);
    case (a)
      5'h00: return m_bmcr;
      5'h01: return 16'h7909 + (m_latched ? 16'h0004 : 16'h0) + (link_up ? 16'h0020 : 16'h0);
      5'h02: return 16'h0141;
      5'h03: return 16'h0CC2;
      5'h1A: return (16'(speed_in) * 16'd16) + (link_up ? 16'd4 : 16'd0);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic send_bit(input logic b, input bit do_rst);
    mdc = 1'b0;
    st_drv = b;
    if (do_rst) begin
      #40 rst_n = 1'b0;
      #1;
      check("rst_release_oe", 32'(mdio_oe), 32'd0);
      check("rst_bmcr", 32'(bmcr_o), 32'h1140);
      #19 rst_n = 1'b1;
      #20;
    end else begin
      #80;
    end
    mdc = 1'b1;
    #80;
  endtask

  task automatic frame(input int pre, input bit lead0, input bit rd, input logic [4:0] pa,
                       input logic [4:0] ra, input logic [15:0] wd, input int rst_bit);
    logic [13:0] hdr;
    logic [17:0] tw;
    hdr = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra};
    tw  = {2'b10, wd};
    st_oe = 1'b1;
    if (lead0) send_bit(1'b0, 1'b0);
    repeat (pre) send_bit(1'b1, 1'b0);
    for (int i = 13; i >= 0; i--) send_bit(hdr[i], 1'b0);
    if (rd) begin
      st_oe = 1'b0;
      for (int i = 0; i < 18; i++) send_bit(1'b1, (14 + i) == rst_bit);
    end else begin
      for (int i = 17; i >= 0; i--) send_bit(tw[i], 1'b0);
    end
    st_oe = 1'b0;
    mdc = 1'b0;
    #80;
  endtask

  task automatic do_read(input logic [4:0] pa, input logic [4:0] ra, input int pre, input bit lead0,
                         input int rst_bit);
    int   oe0;
    exp_t e;
    bit   answered;
    oe0 = oe_cnt;
    answered = (pa == 5'd1) && (pre >= 32);
    if (answered) begin
      e.abort_exp = (rst_bit >= 0);
      e.data = model_read(ra);
      exp_q.push_back(e);
      if (ra == 5'h01 && rst_bit < 0) m_latched = link_up;
    end
    frame(pre, lead0, 1'b1, pa, ra, 16'h0, rst_bit);
    if (rst_bit >= 0) begin
      m_bmcr = 16'h1140;
      m_latched = 1'b0;
    end
    if (!answered) check("no_drive", 32'(oe_cnt - oe0), 32'd0);
    #160;
  endtask

  task automatic do_write(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
    frame(32, 1'b0, 1'b0, pa, ra, wd, -1);
    if (pa == 5'd1 && ra == 5'h00 && !m_bmcr[15])
      m_bmcr = wd[15] ? 16'h9140 : (wd & 16'h7FFF);
    check("bmcr_after_wr", 32'(bmcr_o), 32'(m_bmcr));
    #160;
  endtask

  task automatic set_link(input logic v);
    link_up = v;
    if (!v) m_latched = 1'b0;
    #20;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [15:0] d;
    bit          ab;
    forever begin
      @(posedge mdio_oe);
      check("ta_drive0", 32'(mdio_o), 32'd0);
      check("ta_half_mdc", 32'(mdc), 32'd0);
      ab = 1'b0;
      d = '0;
      @(posedge mdc);
      if (!mdio_oe) ab = 1'b1;
      else check("ta2_zero", 32'(mdio_line), 32'd0);
      for (int i = 0; i < 16 && !ab; i++) begin
        @(posedge mdc);
        if (!mdio_oe) ab = 1'b1;
        else d = {d[14:0], mdio_line};
      end
      check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rsp_aborted", 32'(ab), 32'(e.abort_exp));
        if (!e.abort_exp && !ab) begin
          check("rd_data", 32'(d), 32'(e.data));
          @(negedge mdc);
          repeat (6) @(negedge clk);
          check("oe_release", 32'(mdio_oe), 32'd0);
        end
      end
    end
  end

  initial begin : stim
    int          sr0, hi0;
    logic [4:0]  pa, ra;
    logic [4:0]  addrs [6];
    #20;
    check("rst_bmcr0", 32'(bmcr_o), 32'h1140);
    check("rst_oe0", 32'(mdio_oe), 32'd0);
    check("rst_o0", 32'(mdio_o), 32'd1);
    check("rst_soft0", 32'(soft_rst_o), 32'd0);
    #30 rst_n = 1'b1;
    #50;

    set_link(1'b1);
    do_read(5'd1, 5'h01, 32, 1'b0, -1);
    do_read(5'd1, 5'h01, 32, 1'b0, -1);

    do_write(5'd1, 5'h00, 16'h2100);
    do_read(5'd1, 5'h00, 32, 1'b0, -1);

    sr0 = sr_cnt;
    hi0 = hi_cnt;
    do_write(5'd1, 5'h00, 16'h9140);
    do_write(5'd1, 5'h00, 16'h0000);
    for (int i = 0; i < 4000 && bmcr_o !== 16'h1140; i++) @(negedge clk);
    m_bmcr = 16'h1140;
    check("bmcr_after_srst", 32'(bmcr_o), 32'(m_bmcr));
    check("srst_bit15_cycles", 32'(hi_cnt - hi0), 32'(RSTC));
    check("soft_rst_pulses", 32'(sr_cnt - sr0), 32'd1);
    do_read(5'd1, 5'h00, 32, 1'b0, -1);

    do_read(5'd2, 5'h02, 32, 1'b0, -1);
    do_read(5'd1, 5'h02, 32, 1'b0, -1);

    do_read(5'd1, 5'h01, 31, 1'b1, -1);
    speed_in = 2'b10;
    set_link(1'b1);
    do_read(5'd1, 5'h1A, 32, 1'b0, -1);

    do_write(5'd1, 5'h00, 16'h0100);
    do_read(5'd1, 5'h03, 32, 1'b0, 23);
    do_read(5'd1, 5'h02, 32, 1'b0, -1);

    addrs[0] = 5'h00; addrs[1] = 5'h01; addrs[2] = 5'h02;
    addrs[3] = 5'h03; addrs[4] = 5'h1A; addrs[5] = 5'h00;
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 2) == 0) set_link(1'($urandom_range(0, 1)));
      speed_in = 2'($urandom_range(0, 2));
      pa = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
      ra = ($urandom_range(0, 5) == 5) ? 5'($urandom_range(4, 31)) : addrs[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) do_read(pa, ra, 32, 1'b0, -1);
      else do_write(pa, ra, 16'($urandom) & 16'h7FFF);
    end

    #2000;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdio_phy_resp.md
MDIO_PHY_RESP -- requirements
Module: mdio_phy_resp

Interface
REQ-001 Parameter PHY_ADDR, default 5'd1: PHY address this responder answers to.
REQ-002 Parameter PHY_ID1, default 16'h0141: value returned for register 0x02.
REQ-003 Parameter PHY_ID2, default 16'h0CC2: value returned for register 0x03.
REQ-004 Parameter RST_CYC, default 16'd1000: clk cycles for which BMCR bit15 stays set after a soft-reset write.
REQ-005 clk  input  1  system clock; clk frequency SHALL be at least 8x MDC frequency.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 mdc  input  1  management clock from the station, asynchronous to clk.
REQ-008 mdio_i  input  1  MDIO line as seen at the pad.
REQ-009 mdio_o  output  1  MDIO drive value.
REQ-010 mdio_oe  output  1  MDIO drive enable, 1 = drive mdio_o.
REQ-011 link_up  input  1  current link status from the PHY datapath.
REQ-012 speed_in  input  2  current speed: 2'b10 = 1000M, 2'b01 = 100M, 2'b00 = 10M.
REQ-013 bmcr_o  output  16  current BMCR (register 0x00) contents.
REQ-014 soft_rst_o  output  1  one-cycle pulse on accepted soft-reset write.

Function
REQ-015 mdc and mdio_i SHALL pass through 2-flop synchronizers; MDC rising and falling edges are detected in clk domain; mdio_i is sampled on detected MDC rising edges only.
REQ-016 Frame format is Clause 22: preamble, ST=01, OP (10 read, 01 write), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], all MSB first.
REQ-017 FSM states: IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA.
REQ-018 IDLE counts consecutive sampled 1s, saturating at 32; a sampled 0 with count = 32 moves to ST (the 0 is the first ST bit); a sampled 0 with count < 32 clears the count and stays IDLE.
REQ-019 ST: sampled 1 -> OP; sampled 0 -> IDLE.
REQ-020 OP: after 2 bits, 10 or 01 -> PHYAD; 00 or 11 -> IDLE.
REQ-021 PHYAD: after 5 bits, mismatch with PHY_ADDR -> IDLE with no drive for the remainder of the frame; match -> REGAD.
REQ-022 REGAD: after 5 bits -> TA; register read data is latched at this point.
REQ-023 Read TA: mdio_oe stays 0 through first TA bit; on the MDC falling edge after the first TA rising edge, mdio_oe=1, mdio_o=0.
REQ-024 RDATA: on each subsequent MDC falling edge mdio_o presents D15..D0 in order; on the falling edge after the rising edge that completes D0, mdio_oe=0 and FSM -> IDLE.
REQ-025 Write TA: 2 bits sampled and ignored -> WDATA; after 16 data bits, the register write is committed in the clk cycle following the last sampling edge, FSM -> IDLE.
REQ-026 Every state exit to IDLE SHALL clear the preamble count.
REQ-027 Register map: 0x00 BMCR (R/W); 0x01 BMSR (RO); 0x02 PHY_ID1; 0x03 PHY_ID2; 0x1A status (RO); all other addresses read 16'h0000, writes ignored.
REQ-028 BMSR = 16'h7909 | (link_latched<<2) | (link_up<<5).
REQ-029 link_latched is latching-low: cleared in any cycle link_up=0; set to link_up at the commit of a read of 0x01 (after the read data latch), so the read returns the latched value.
REQ-030 Register 0x1A = {10'b0, speed_in, 1'b0, link_up, 2'b00}.
REQ-031 Write to 0x00 with D15=0: bmcr_o <= D (bits 14:0), bit15 stays 0.
REQ-032 Write to 0x00 with D15=1: bmcr_o <= 16'h9140, soft_rst_o pulses one cycle, a counter runs RST_CYC cycles then clears bmcr_o[15] (-> 16'h1140).
REQ-033 Writes to 0x00 while bit15 is set are ignored; reads return current value.
REQ-034 Write to read-only registers SHALL have no effect.

Reset
REQ-035 On rst_n=0: FSM IDLE, counters 0, mdio_oe=0, mdio_o=1, bmcr_o=16'h1140, soft_rst_o=0, link_latched=0, synchronizers cleared.
REQ-036 rst_n asserted mid-frame SHALL release the bus immediately; the frame is discarded.

Verification
REQ-037 link_up=1 held, 32-bit preamble + read PHYAD=1 REGAD=0x01 twice -> 1st read 16'h7909|0x20 (latched 0), 2nd 16'h792D.
REQ-038 Write 16'h2100 to 0x00 then read 0x00 -> bmcr_o=16'h2100, read returns 16'h2100, TA drive 0 exactly one half-MDC after TA1.
REQ-039 Write 16'h9140 to 0x00 -> soft_rst_o one pulse, bmcr_o=16'h9140 for RST_CYC cycles then 16'h1140; write of 16'h0000 during that window ignored.
REQ-040 Read with PHYAD=5'd2 -> mdio_oe remains 0 for the whole frame; next valid frame answered normally.
REQ-041 Preamble of 31 ones then read frame -> no response; speed_in=2'b10, link_up=1, read 0x1A with full preamble -> 16'h0024.
REQ-042 rst_n pulsed during RDATA bit D8 -> mdio_oe=0 asynchronously, bmcr_o=16'h1140, next full frame answered.
